fb_scan_reader: RTL

- Pixel-domain stage between the Mandelbrot framebuffer read port and the HDMI/DVI encoder's rgb input.
- Takes the encoder's raster position (cx, cy, frame_width, frame_height) and issues latency-compensated framebuffer reads, so each pixel's iteration index arrives in the cycle that pixel is scanned.
- Maps the index through a runtime-writable palette and drives a registered 24-bit rgb word, black outside the active area.

---
 rtl/fb_scan_reader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: pixel-domain framebuffer scan-out stage.
// Issues framebuffer reads READ_DELAY pixels ahead of the raster so that each
// iteration index lands in the cycle its pixel is scanned, maps it through a
// writable 24-bit palette and drives a registered rgb word (black outside the
// active area).
// Optional build macro: FB_PALETTE_CYCLE_EN -- rotates the palette lookup by
// one entry every 2^CYCLE_SHIFT frames.
module fb_scan_reader #(
   parameter int WIDTH       = 1280,
   parameter int HEIGHT      = 720,
   parameter int W_BITS      = 11,
   parameter int H_BITS      = 10,
   parameter int ADDR_BITS   = 22,
   parameter int DATA_BITS   = 4,
   parameter int READ_DELAY  = 2,
   parameter int CYCLE_SHIFT = 3
) (
   input  logic                 clk_pixel,
   input  logic                 reset,
   input  logic [W_BITS-1:0]    cx,
   input  logic [H_BITS-1:0]    cy,
   input  logic [W_BITS-1:0]    frame_width,
   input  logic [H_BITS-1:0]    frame_height,
   output logic                 read_en,
   output logic [ADDR_BITS-1:0] read_addr,
   input  logic [DATA_BITS-1:0] read_data,
   input  logic                 pal_we,
   input  logic [DATA_BITS-1:0] pal_addr,
   input  logic [23:0]          pal_wdata,
   output logic [23:0]          rgb,
   output logic                 frame_start
);

   localparam int PAL_N = 1 << DATA_BITS;
   localparam logic [ADDR_BITS-1:0] WIDTH_A  = ADDR_BITS'(WIDTH);
   localparam logic [ADDR_BITS-1:0] HEIGHT_A = ADDR_BITS'(HEIGHT);

   // Reject parameter sets the pipeline cannot honour.
   if ((READ_DELAY < 1) || (READ_DELAY > 4) || (CYCLE_SHIFT < 1) ||
       (DATA_BITS < 1) || ((WIDTH * HEIGHT) > (2 ** ADDR_BITS))) begin : g_param_check
      $error("fb_scan_reader: illegal parameter combination");
   end

   // Power-up palette: 16-step gradient, repeated if the palette is larger.
   function automatic logic [23:0] default_color(input int i);
      logic [3:0] sel;
      sel = 4'(i);
      case (sel)
         4'd0:    default_color = 24'h421e0f;
         4'd1:    default_color = 24'h19071a;
         4'd2:    default_color = 24'h09012f;
         4'd3:    default_color = 24'h040449;
         4'd4:    default_color = 24'h000764;
         4'd5:    default_color = 24'h0c2c8a;
         4'd6:    default_color = 24'h1852b1;
         4'd7:    default_color = 24'h397dd1;
         4'd8:    default_color = 24'h86b5e5;
         4'd9:    default_color = 24'hd3ecf8;
         4'd10:   default_color = 24'hf1e9bf;
         4'd11:   default_color = 24'hf8c95f;
         4'd12:   default_color = 24'hffaa00;
         4'd13:   default_color = 24'hcc8000;
         4'd14:   default_color = 24'h995700;
         4'd15:   default_color = 24'h6a3403;
         default: default_color = 24'h000000;
      endcase
   endfunction

   logic [W_BITS:0]          lx_sum_s;
   logic [H_BITS:0]          ly_inc_s;
   logic [W_BITS-1:0]        lx_s;
   logic [H_BITS-1:0]        ly_s;
   logic [ADDR_BITS-1:0]     lx_a_s;
   logic [ADDR_BITS-1:0]     ly_a_s;
   logic                     in_range_s;
   logic [ADDR_BITS-1:0]     addr_next_s;
   logic                     active_now_s;
   logic [READ_DELAY-1:0]    vld_sr_r;
   logic                     vld_s;
   logic [DATA_BITS-1:0]     idx_s;
   logic [23:0]              pal_rd_s;
   logic [23:0]              pal_flat_s [PAL_N];

   // Lookahead position: READ_DELAY columns ahead, wrapping into the next line/frame.
   always_comb begin
      lx_sum_s = {1'b0, cx} + (W_BITS+1)'(READ_DELAY);
      ly_inc_s = {1'b0, cy} + {{H_BITS{1'b0}}, 1'b1};
      lx_s     = cx;
      ly_s     = cy;
      if (lx_sum_s >= {1'b0, frame_width}) begin
         lx_s = W_BITS'(lx_sum_s - {1'b0, frame_width});
         if (ly_inc_s >= {1'b0, frame_height}) begin
            ly_s = {H_BITS{1'b0}};
         end else begin
            ly_s = ly_inc_s[H_BITS-1:0];
         end
      end else begin
         lx_s = lx_sum_s[W_BITS-1:0];
         ly_s = cy;
      end
   end

   // Address arithmetic at full address width; blanking positions are not fetched.
   always_comb begin
      lx_a_s       = ADDR_BITS'(lx_s);
      ly_a_s       = ADDR_BITS'(ly_s);
      in_range_s   = (lx_a_s < WIDTH_A) && (ly_a_s < HEIGHT_A);
      addr_next_s  = (ly_a_s * WIDTH_A) + lx_a_s;
      active_now_s = (ADDR_BITS'(cx) < WIDTH_A) && (ADDR_BITS'(cy) < HEIGHT_A);
   end

   // Address stage: register the read request; the address holds while idle.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         read_en   <= 1'b0;
         read_addr <= {ADDR_BITS{1'b0}};
      end else begin
         read_en <= in_range_s;
         if (in_range_s) begin
            read_addr <= addr_next_s;
         end
      end
   end

   // Valid pipe: delays the fetch request until its data appears on read_data.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         vld_sr_r <= {READ_DELAY{1'b0}};
      end else begin
         vld_sr_r[0] <= in_range_s;
         for (int k = 1; k < READ_DELAY; k++) begin
            vld_sr_r[k] <= vld_sr_r[k-1];
         end
      end
   end

   assign vld_s = vld_sr_r[READ_DELAY-1];

   // Palette register file; each entry powers up to the default gradient and
   // is never touched by reset. A same-cycle pixel read sees the old value.
   for (genvar g = 0; g < PAL_N; g++) begin : g_pal
      logic [23:0] entry_r = default_color(g);

      // Entry write port.
      always_ff @(posedge clk_pixel) begin
         if (pal_we && (pal_addr == DATA_BITS'(g))) begin
            entry_r <= pal_wdata;
         end
      end

      assign pal_flat_s[g] = entry_r;
   end

`ifdef FB_PALETTE_CYCLE_EN
   logic [CYCLE_SHIFT:0]  frame_cnt_r;
   logic [CYCLE_SHIFT:0]  frame_cnt_inc_s;
   logic [DATA_BITS-1:0]  offset_r;

   assign frame_cnt_inc_s = frame_cnt_r + {{CYCLE_SHIFT{1'b0}}, 1'b1};

   // Frame counter; bump the rotation offset each time its low bits wrap.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         frame_cnt_r <= {(CYCLE_SHIFT+1){1'b0}};
         offset_r    <= {DATA_BITS{1'b0}};
      end else if (frame_start) begin
         frame_cnt_r <= frame_cnt_inc_s;
         if (frame_cnt_inc_s[CYCLE_SHIFT-1:0] == {CYCLE_SHIFT{1'b0}}) begin
            offset_r <= offset_r + {{(DATA_BITS-1){1'b0}}, 1'b1};
         end
      end
   end

   // Rotated palette index (wraps mod 2^DATA_BITS).
   always_comb begin
      idx_s    = read_data + offset_r;
      pal_rd_s = pal_flat_s[idx_s];
   end
`else
   // Palette index is the raw iteration count.
   always_comb begin
      idx_s    = read_data;
      pal_rd_s = pal_flat_s[idx_s];
   end
`endif

   // Output stage: colour for the position sampled this edge, black when invalid.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         rgb <= 24'h000000;
      end else if (vld_s && active_now_s) begin
         rgb <= pal_rd_s;
      end else begin
         rgb <= 24'h000000;
      end
   end

   // Frame marker: one cycle after the raster origin is sampled.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= (cx == {W_BITS{1'b0}}) && (cy == {H_BITS{1'b0}});
      end
   end

endmodule
